// File: rtl/wb_writeback_unit_pkg.sv
// rtl/wb_writeback_unit_pkg.sv - shared pipeline widths and write-back control encodings
package wb_writeback_unit_pkg;

  localparam int PIPE_DATA_W   = 32;
  localparam int PIPE_ADDR_W   = 5;
  localparam int PIPE_NUM_REGS = 1 << PIPE_ADDR_W;

  localparam logic CTRL_ON  = 1'b1;
  localparam logic CTRL_OFF = 1'b0;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/wb_writeback_unit_regfile.sv
// rtl/wb_writeback_unit_regfile.sv - two asynchronous read ports, one write port, register 0 tied to zero
module regfile_2r1w
  import wb_writeback_unit_pkg::*;
#(
  parameter int DATA_W   = PIPE_DATA_W,
  parameter int ADDR_W   = PIPE_ADDR_W,
  parameter int NUM_REGS = PIPE_NUM_REGS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Entry 0 is only ever reset, never written, so it reads as zero without a read-side mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

endmodule

// File: rtl/wb_writeback_unit.sv
// rtl/wb_writeback_unit.sv - MEM/WB pipeline register, write-back select, register file and retire counter
module wb_writeback_unit
  import wb_writeback_unit_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int ADDR_W = PIPE_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic              mem_memtoreg,
  input  logic [ADDR_W-1:0] mem_write_register,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  output logic [31:0]       retire_count
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic              wb_valid;
  logic              wb_written;
  logic              wb_regwrite;
  logic              wb_memtoreg;
  logic [ADDR_W-1:0] wb_write_register;
  logic [DATA_W-1:0] wb_alu_result;
  logic [DATA_W-1:0] wb_read_data;
  logic              wb_retire;
  wb_src_e           wb_src;

  // wb_written marks an instruction that already wrote while held by stall, so it writes once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid          <= CTRL_OFF;
      wb_written        <= CTRL_OFF;
      wb_regwrite       <= CTRL_OFF;
      wb_memtoreg       <= CTRL_OFF;
      wb_write_register <= '0;
      wb_alu_result     <= '0;
      wb_read_data      <= '0;
    end else if (flush) begin
      wb_valid   <= CTRL_OFF;
      wb_written <= CTRL_OFF;
    end else if (!stall) begin
      wb_valid          <= mem_valid;
      wb_written        <= CTRL_OFF;
      wb_regwrite       <= mem_regwrite;
      wb_memtoreg       <= mem_memtoreg;
      wb_write_register <= mem_write_register;
      wb_alu_result     <= mem_alu_result;
      wb_read_data      <= mem_read_data;
    end else if (wb_valid) begin
      wb_written <= CTRL_ON;
    end
  end

  assign wb_retire = wb_valid && !wb_written;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retire_count <= '0;
    end else if (wb_retire) begin
      retire_count <= retire_count + 32'd1;
    end
  end

  assign wb_src        = wb_src_e'(wb_memtoreg);
  assign WriteData     = (wb_src == WB_SRC_MEM) ? wb_read_data : wb_alu_result;
  assign WriteRegister = wb_write_register;
  assign RegWrite      = wb_retire && wb_regwrite;

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (RegWrite),
    .waddr   (WriteRegister),
    .wdata   (WriteData),
    .raddr1  (rs),
    .raddr2  (rt),
    .rdata1  (ReadData1),
    .rdata2  (ReadData2)
  );

endmodule

// File: tb/tb_wb_writeback_unit.sv
// tb/tb_wb_writeback_unit.sv - directed self-checking bench for wb_writeback_unit
module tb_wb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic [4:0]  mem_write_register;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [31:0] retire_count;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_writeback_unit dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .stall              (stall),
    .flush              (flush),
    .mem_valid          (mem_valid),
    .mem_regwrite       (mem_regwrite),
    .mem_memtoreg       (mem_memtoreg),
    .mem_write_register (mem_write_register),
    .mem_alu_result     (mem_alu_result),
    .mem_read_data      (mem_read_data),
    .rs                 (rs),
    .rt                 (rt),
    .ReadData1          (ReadData1),
    .ReadData2          (ReadData2),
    .WriteRegister      (WriteRegister),
    .WriteData          (WriteData),
    .RegWrite           (RegWrite),
    .retire_count       (retire_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic v, input logic rw, input logic m2r, input logic [4:0] dst,
                       input logic [31:0] alu, input logic [31:0] rd);
    mem_valid          = v;
    mem_regwrite       = rw;
    mem_memtoreg       = m2r;
    mem_write_register = dst;
    mem_alu_result     = alu;
    mem_read_data      = rd;
  endtask

  initial begin
    reset_n = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    rs      = 5'd0;
    rt      = 5'd0;
    issue(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    #3;
    chk("reset_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("reset_wreg", {27'b0, WriteRegister}, 32'd0);
    chk("reset_wdata", WriteData, 32'd0);
    chk("reset_rd1", ReadData1, 32'd0);
    chk("reset_retire", retire_count, 32'd0);
    tick();
    reset_n = 1'b1;

    // basic ALU write to r5
    issue(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
    tick();
    issue(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs = 5'd5;
    chk("basic_regwrite", {31'b0, RegWrite}, 32'd1);
    chk("basic_wdata", WriteData, 32'h1234);
    chk("basic_wreg", {27'b0, WriteRegister}, 32'd5);
    chk("basic_no_bypass", ReadData1, 32'd0);
    chk("basic_retire_pre", retire_count, 32'd0);
    tick();
    chk("basic_rd1", ReadData1, 32'h1234);
    chk("basic_regwrite_after", {31'b0, RegWrite}, 32'd0);
    chk("basic_retire", retire_count, 32'd1);

    // memory-data path to r7
    issue(1'b1, 1'b1, 1'b1, 5'd7, 32'h1, 32'hDEADBEEF);
    tick();
    issue(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rt = 5'd7;
    chk("mem_wdata", WriteData, 32'hDEADBEEF);
    tick();
    chk("mem_rd2", ReadData2, 32'hDEADBEEF);
    chk("mem_retire", retire_count, 32'd2);

    // write to r0 is discarded but still retires
    issue(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 32'h0);
    tick();
    issue(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs = 5'd0;
    chk("r0_regwrite", {31'b0, RegWrite}, 32'd1);
    tick();
    chk("r0_rd1", ReadData1, 32'd0);
    chk("r0_retire", retire_count, 32'd3);

    // stall holds a writing instruction for 3 cycles
    issue(1'b1, 1'b1, 1'b0, 5'd10, 32'hA5A5, 32'h0);
    tick();
    issue(1'b1, 1'b1, 1'b0, 5'd11, 32'h5555, 32'h0);
    stall = 1'b1;
    rs = 5'd10;
    chk("stall_regwrite_c0", {31'b0, RegWrite}, 32'd1);
    tick();
    chk("stall_regwrite_c1", {31'b0, RegWrite}, 32'd0);
    chk("stall_rd1", ReadData1, 32'hA5A5);
    chk("stall_retire_c1", retire_count, 32'd4);
    tick();
    chk("stall_regwrite_c2", {31'b0, RegWrite}, 32'd0);
    chk("stall_wreg_held", {27'b0, WriteRegister}, 32'd10);
    tick();
    chk("stall_retire_c3", retire_count, 32'd4);
    stall = 1'b0;
    issue(1'b1, 1'b0, 1'b0, 5'd11, 32'h77, 32'h0);
    tick();
    issue(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs = 5'd11;
    chk("norw_regwrite", {31'b0, RegWrite}, 32'd0);
    tick();
    chk("norw_retire", retire_count, 32'd5);
    chk("norw_rd1", ReadData1, 32'd0);

    // flush with stall loads a bubble even with a new instruction waiting
    issue(1'b1, 1'b1, 1'b0, 5'd12, 32'hBEEF, 32'h0);
    tick();
    stall = 1'b1;
    tick();
    chk("fs_retire_pre", retire_count, 32'd6);
    issue(1'b1, 1'b1, 1'b0, 5'd13, 32'h1313, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fs_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("fs_retire", retire_count, 32'd6);
    tick();
    chk("fs_hold_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("fs_hold_retire", retire_count, 32'd6);
    stall = 1'b0;
    issue(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    rs = 5'd13;
    chk("fs_r13", ReadData1, 32'd0);

    // reset pulse while an r9 write is pending
    issue(1'b1, 1'b1, 1'b0, 5'd9, 32'h9999, 32'h0);
    tick();
    issue(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    rs = 5'd10;
    rt = 5'd9;
    chk("rst_pre_regwrite", {31'b0, RegWrite}, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_regwrite", {31'b0, RegWrite}, 32'd0);
    chk("rst_wreg", {27'b0, WriteRegister}, 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    chk("rst_retire", retire_count, 32'd0);
    chk("rst_r10", ReadData1, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rst_r9", ReadData2, 32'd0);
    chk("rst_retire_after", retire_count, 32'd0);

    // retire counter wrap
    force dut.retire_count = 32'hFFFFFFFF;
    #1;
    release dut.retire_count;
    #1;
    chk("wrap_preload", retire_count, 32'hFFFFFFFF);
    issue(1'b1, 1'b1, 1'b0, 5'd3, 32'h33, 32'h0);
    tick();
    issue(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    rs = 5'd3;
    chk("wrap_retire", retire_count, 32'd0);
    chk("wrap_r3", ReadData1, 32'h33);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_writeback_unit.md
WB_WRITEBACK_UNIT -- requirements
Module: wb_writeback_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; 2**ADDR_W registers.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port stall, input, 1, hold the MEM/WB register.
REQ-006 SHALL have port flush, input, 1, load a bubble into the MEM/WB register.
REQ-007 SHALL have port mem_valid, input, 1, the MEM stage holds a real instruction.
REQ-008 SHALL have ports mem_regwrite and mem_memtoreg, input, 1 each, MEM-stage control.
REQ-009 SHALL have port mem_write_register, input, ADDR_W, destination register.
REQ-010 SHALL have ports mem_alu_result and mem_read_data, input, DATA_W each, the two result candidates.
REQ-011 SHALL have ports rs and rt, input, ADDR_W each, ID-stage read addresses.
REQ-012 SHALL have ports ReadData1 and ReadData2, output, DATA_W each, raw register-file contents at rs and rt.
REQ-013 SHALL have ports WriteRegister (ADDR_W), WriteData (DATA_W) and RegWrite (1), output, the write-back bus consumed by the WB forwarding unit.
REQ-014 SHALL have port retire_count, output, 32, count of retired instructions.

Function
REQ-015 SHALL, on each clk edge with flush=1, clear wb_valid and wb_written regardless of stall; flush has priority.
REQ-016 SHALL, on each clk edge with flush=0 and stall=0, capture all mem_* inputs into the MEM/WB register and clear wb_written.
REQ-017 SHALL, on each clk edge with flush=0 and stall=1, hold the MEM/WB register and set wb_written if wb_valid=1.
REQ-018 SHALL drive WriteData combinationally as wb_read_data when wb_memtoreg=1, else wb_alu_result.
REQ-019 SHALL drive WriteRegister combinationally from wb_write_register.
REQ-020 SHALL drive RegWrite = wb_valid AND wb_regwrite AND NOT wb_written, so a held instruction writes exactly once.
REQ-021 SHALL write WriteData into register WriteRegister at the clk edge where RegWrite=1 and WriteRegister!=0.
REQ-022 SHALL hardwire register 0 to zero; writes to register 0 are discarded and RegWrite is still driven per REQ-020.
REQ-023 SHALL read ReadData1 and ReadData2 asynchronously, without internal write-to-read bypass; same-cycle bypass belongs to the forwarding unit.
REQ-024 SHALL retire an instruction one cycle after capture: data is visible on ReadData the cycle after its RegWrite edge.
REQ-025 SHALL increment retire_count by 1 at each edge where wb_valid=1 and wb_written=0, regardless of wb_regwrite.
REQ-026 SHALL wrap retire_count from 0xFFFFFFFF to 0.

Reset
REQ-027 SHALL, while reset_n=0, asynchronously force wb_valid=0, wb_written=0, all MEM/WB fields=0, all registers=0, and retire_count=0.
REQ-028 SHALL therefore drive RegWrite=0, WriteRegister=0 and WriteData=0 during reset.
REQ-029 SHALL leave ReadData1 and ReadData2 at 0 during reset.
REQ-030 SHALL abandon an in-flight write when reset asserts mid-operation; no write occurs on the edge at which reset deasserts.

Structure
REQ-031 SHALL take DATA_W, ADDR_W and NUM_REGS defaults from the shared pipeline package, alongside the pipeline control-bit constants.
REQ-032 SHALL instantiate one sub-module regfile_2r1w, which holds the register array, the two asynchronous read ports and the one write port; the MEM/WB register, select and counter stay in wb_writeback_unit.

Verification
REQ-033 SHALL cover basic write: mem_valid=1, mem_regwrite=1, mem_memtoreg=0, dest=5, alu=0x1234 -> next cycle RegWrite=1, WriteData=0x1234; after that edge, rs=5 gives ReadData1=0x1234.
REQ-034 SHALL cover the memory-data path: mem_memtoreg=1, dest=7, read_data=0xDEADBEEF, alu=0x1 -> WriteData=0xDEADBEEF and reg7=0xDEADBEEF.
REQ-035 SHALL cover register 0: dest=0, alu=0xFFFFFFFF -> ReadData1 at rs=0 stays 0; retire_count increments by 1.
REQ-036 SHALL cover stall: a write instruction in WB held 3 cycles with stall=1 -> RegWrite high for 1 cycle only and retire_count +1 only.
REQ-037 SHALL cover flush with stall: flush=1 and stall=1 together -> RegWrite=0 next cycle and retire_count unchanged.
REQ-038 SHALL cover reset mid-operation: reset_n pulsed low while RegWrite=1 for dest=9 -> reg9=0, retire_count=0 and all outputs 0; retire_count preloaded to 0xFFFFFFFF wraps to 0 on the next retire.
